// File: rtl/input_trim_if.sv
// input_trim_if: push-button inputs, level select and captured-sequence outputs of input_trim.
interface input_trim_if;
  logic [1:0] level;
  logic botton_1, botton_2, botton_3, botton_4, botton_5, botton_6, botton_7, botton_8;
  logic [2:0] trimmed_inp_1, trimmed_inp_2, trimmed_inp_3, trimmed_inp_4;
  logic [2:0] trimmed_inp_5, trimmed_inp_6, trimmed_inp_7, trimmed_inp_8;
  logic [2:0] trimmed_inp_9, trimmed_inp_10, trimmed_inp_11, trimmed_inp_12;
  logic [2:0] trimmed_inp_13, trimmed_inp_14, trimmed_inp_15, trimmed_inp_16;
  logic end_signal;
  logic [3:0] error_code;
  modport master (
    output level, botton_1, botton_2, botton_3, botton_4, botton_5, botton_6, botton_7, botton_8,
    input trimmed_inp_1, trimmed_inp_2, trimmed_inp_3, trimmed_inp_4,
          trimmed_inp_5, trimmed_inp_6, trimmed_inp_7, trimmed_inp_8,
          trimmed_inp_9, trimmed_inp_10, trimmed_inp_11, trimmed_inp_12,
          trimmed_inp_13, trimmed_inp_14, trimmed_inp_15, trimmed_inp_16,
          end_signal, error_code
  );
  modport slave (
    input level, botton_1, botton_2, botton_3, botton_4, botton_5, botton_6, botton_7, botton_8,
    output trimmed_inp_1, trimmed_inp_2, trimmed_inp_3, trimmed_inp_4,
           trimmed_inp_5, trimmed_inp_6, trimmed_inp_7, trimmed_inp_8,
           trimmed_inp_9, trimmed_inp_10, trimmed_inp_11, trimmed_inp_12,
           trimmed_inp_13, trimmed_inp_14, trimmed_inp_15, trimmed_inp_16,
           end_signal, error_code
  );
endinterface

// File: rtl/input_trim.sv
// input_trim: records one-hot button press events into up to 16 ordered 3-bit slots.
// Define INPUT_TRIM_SYNC_EN to pass the buttons through a 2-flop synchronizer first.
module input_trim #(
  parameter int NUM_SLOTS = 16,
  parameter int SLOTS_PER_LEVEL = 4
) (
  input logic clk,
  input logic rst,
  input_trim_if.slave bus
);
  logic [7:0] b, b_s, p_q, p_d;
  logic [2:0] slot_q [NUM_SLOTS];
  logic [2:0] slot_d [NUM_SLOTS];
  logic [4:0] i_q, i_d, max_w;
  logic [3:0] err_q, err_d;
  logic end_q, end_d, evt, one_hot, full;
  logic [2:0] code;
  assign b = {bus.botton_8, bus.botton_7, bus.botton_6, bus.botton_5,
              bus.botton_4, bus.botton_3, bus.botton_2, bus.botton_1};
`ifdef INPUT_TRIM_SYNC_EN
  logic [7:0] s1_q, s2_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= b;
      s2_q <= s1_q;
    end
  assign b_s = s2_q;
`else
  assign b_s = b;
`endif
  assign max_w = 5'(SLOTS_PER_LEVEL) * ({3'b0, bus.level} + 5'd1);
  assign evt = (p_q == 8'd0) && (b_s != 8'd0);
  assign one_hot = (b_s & (b_s - 8'd1)) == 8'd0;
  assign full = i_q >= max_w;
  always_comb begin
    code = 3'd0;
    for (int k = 0; k < 8; k++) if (b_s[k]) code = 3'(k);
  end
  always_comb begin
    slot_d = slot_q;
    i_d = i_q;
    err_d = err_q;
    p_d = b_s;
    if (evt) begin
      if (full) err_d = 4'b0010;
      else if (!one_hot) err_d = 4'b0001;
      else begin
        slot_d[i_q[3:0]] = code;
        i_d = i_q + 5'd1;
        err_d = 4'b0000;
      end
    end
    end_d = i_d >= max_w;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      slot_q <= '{default: '0};
      i_q <= '0;
      p_q <= '0;
      err_q <= '0;
      end_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      i_q <= i_d;
      p_q <= p_d;
      err_q <= err_d;
      end_q <= end_d;
    end
  assign bus.trimmed_inp_1 = slot_q[0];
  assign bus.trimmed_inp_2 = slot_q[1];
  assign bus.trimmed_inp_3 = slot_q[2];
  assign bus.trimmed_inp_4 = slot_q[3];
  assign bus.trimmed_inp_5 = slot_q[4];
  assign bus.trimmed_inp_6 = slot_q[5];
  assign bus.trimmed_inp_7 = slot_q[6];
  assign bus.trimmed_inp_8 = slot_q[7];
  assign bus.trimmed_inp_9 = slot_q[8];
  assign bus.trimmed_inp_10 = slot_q[9];
  assign bus.trimmed_inp_11 = slot_q[10];
  assign bus.trimmed_inp_12 = slot_q[11];
  assign bus.trimmed_inp_13 = slot_q[12];
  assign bus.trimmed_inp_14 = slot_q[13];
  assign bus.trimmed_inp_15 = slot_q[14];
  assign bus.trimmed_inp_16 = slot_q[15];
  assign bus.end_signal = end_q;
  assign bus.error_code = err_q;
endmodule

// File: tb/tb_input_trim.sv
// tb_input_trim: directed press sequences checked against a behavioural model through a scoreboard queue.
module tb_input_trim;
  logic clk = 1'b0;
  logic rst = 1'b0;
  input_trim_if bus ();
  input_trim dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [47:0] slots;
    logic en;
    logic [3:0] err;
  } exp_t;
  exp_t sb[$];
  int n_assert = 0;
  int n_fail = 0;
  logic [2:0] m_slot [16];
  int m_i;
  logic [3:0] m_err;
  logic [47:0] dut_slots;
  assign dut_slots = {bus.trimmed_inp_16, bus.trimmed_inp_15, bus.trimmed_inp_14, bus.trimmed_inp_13,
                      bus.trimmed_inp_12, bus.trimmed_inp_11, bus.trimmed_inp_10, bus.trimmed_inp_9,
                      bus.trimmed_inp_8, bus.trimmed_inp_7, bus.trimmed_inp_6, bus.trimmed_inp_5,
                      bus.trimmed_inp_4, bus.trimmed_inp_3, bus.trimmed_inp_2, bus.trimmed_inp_1};
  task automatic set_btn(input logic [7:0] m);
    {bus.botton_8, bus.botton_7, bus.botton_6, bus.botton_5,
     bus.botton_4, bus.botton_3, bus.botton_2, bus.botton_1} = m;
  endtask
  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_slot[k] = 3'd0;
    m_i = 0;
    m_err = 4'd0;
  endtask
  task automatic model_event(input logic [7:0] m);
    int c = 0;
    if (m_i >= 4 * (int'(bus.level) + 1)) m_err = 4'b0010;
    else if ($countones(m) != 1) m_err = 4'b0001;
    else begin
      for (int k = 0; k < 8; k++) if (m[k]) c = k;
      m_slot[m_i] = c[2:0];
      m_i++;
      m_err = 4'b0000;
    end
  endtask
  task automatic push_exp();
    exp_t e;
    for (int k = 0; k < 16; k++) e.slots[3*k +: 3] = m_slot[k];
    e.en = m_i >= 4 * (int'(bus.level) + 1);
    e.err = m_err;
    sb.push_back(e);
  endtask
  task automatic check(input string tag);
    exp_t e;
    n_assert++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s scoreboard: got empty queue, expected an entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_assert++;
      assert (dut_slots === e.slots) else begin
        n_fail++;
        $error("FAIL %s slots: got %h expected %h", tag, dut_slots, e.slots);
      end
      n_assert++;
      assert (bus.end_signal === e.en) else begin
        n_fail++;
        $error("FAIL %s end_signal: got %b expected %b", tag, bus.end_signal, e.en);
      end
      n_assert++;
      assert (bus.error_code === e.err) else begin
        n_fail++;
        $error("FAIL %s error_code: got %b expected %b", tag, bus.error_code, e.err);
      end
    end
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask
  task automatic press(input logic [7:0] m, input int hold, input string tag);
    @(negedge clk);
    set_btn(m);
    model_event(m);
    push_exp();
    idle(hold);
    set_btn(8'd0);
    idle(4);
    check(tag);
  endtask
  task automatic press_add(input logic [7:0] m1, input logic [7:0] m2, input string tag);
    @(negedge clk);
    set_btn(m1);
    model_event(m1);
    push_exp();
    idle(3);
    set_btn(m1 | m2);
    idle(3);
    set_btn(8'd0);
    idle(4);
    check(tag);
  endtask
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    push_exp();
    #1 check(tag);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
  endtask
  initial begin
    set_btn(8'd0);
    bus.level = 2'd2;
    model_reset();
    idle(2);
    push_exp();
    check("reset");
    rst = 1'b1;
    idle(2);
    press(8'h01, 1, "b1");
    press(8'h02, 1, "b2");
    press(8'h0C, 1, "b3b4_multi");
    press(8'h10, 1, "b5_after_multi");
    press(8'h20, 6, "b6_held");
    press_add(8'h40, 8'h01, "b7_plus_b1");
    for (int k = 0; k < 7; k++) press(8'h01 << (k % 8), 1, $sformatf("fill%0d", k));
    press(8'h80, 1, "overflow_b8");
    press(8'h03, 1, "overflow_multi");
    async_reset("reset_lvl3");
    bus.level = 2'd3;
    for (int k = 0; k < 16; k++) press(8'h01 << (k % 8), 2, $sformatf("cyc%0d", k));
    async_reset("reset_mid");
    for (int k = 0; k < 5; k++) press(8'h80 >> k, 1, $sformatf("pre%0d", k));
    async_reset("reset_async");
    press(8'h04, 1, "first_after_reset");
    for (int k = 0; k < 4; k++) press(8'h08, 1, $sformatf("more%0d", k));
    @(negedge clk);
    bus.level = 2'd0;
    idle(2);
    push_exp();
    check("level_lowered");
    press(8'h01, 1, "lowered_overflow");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/input_trim.md
Name: input_trim

Overview:
- Captures a sequence of discrete button presses from 8 push-buttons.
- Each press is encoded as a 3-bit code and stored into one of up to 16 ordered slots.
- Sequence length is set by `level`.
- Sits between the board button inputs and the game/compare logic. It flags a completed sequence with `end_signal` and reports illegal input on `error_code`.

Parameters:
- NUM_SLOTS, 16, number of storage slots (fixed 16; ports are sized for 16).
- SLOTS_PER_LEVEL, 4, slots added per level step; MAX = SLOTS_PER_LEVEL*(level+1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- level  input  2  difficulty; MAX = 4, 8, 12, 16 for level 0, 1, 2, 3.
- botton_1..botton_8  input  1 each  push-buttons, active-high, level-sensitive.
- trimmed_inp_1..trimmed_inp_16  output  3 each  stored codes; slot k holds the k-th accepted press.
- end_signal  output  1  high when the accepted count is at least MAX.
- error_code  output  4  last error event.

Behaviour:
- Reset (rst=0, asynchronous):
  - All slots = 0.
  - Internal count i (5-bit) = 0.
  - Previous-button register = 0.
  - end_signal = 0, error_code = 4'b0000.
- Sampling:
  - The 8 buttons form vector B (bit0 = botton_1), sampled each clk rising edge.
  - Register P holds B from the previous edge.
- Press event: occurs when P == 0 and B != 0, i.e. the rising edge of "any button".
  - A button held for many cycles produces exactly one event.
  - A button added while another is still held does not produce an event; it is ignored with no error.
- Valid press: event with B one-hot (exactly one button) and i < MAX.
  - Slot i+1 gets code k-1, where botton_k is high (botton_1 = 3'd0 … botton_8 = 3'd7).
  - i increments.
  - error_code is cleared to 0000.
  - The result is visible one cycle after the edge that sampled the press.
- Multi-press: event with two or more bits of B set.
  - Nothing is stored and i is unchanged.
  - error_code = 4'b0001.
- Overflow: any event while i >= MAX.
  - Nothing is stored and i is unchanged.
  - error_code = 4'b0010.
  - Multi-press while full also reports 0010; overflow has priority.
- end_signal:
  - Registered; equals (i >= MAX), updated on the same edge that changes i.
  - Asserts on the edge storing the MAX-th press.
  - Remains high until reset.
- level:
  - Must be held stable while a sequence is in progress.
  - MAX is decoded combinationally.
  - If level is lowered so that MAX <= i, end_signal rises on the next edge; no slots are cleared.
- Slot contents:
  - Slots above i read 0.
  - Stored slots never change until reset.
- error_code values 0011–1111 are reserved and never driven.
- Reset asserted mid-sequence: the sequence is cleared immediately. The first press after reset release goes to slot 1.

Optional Feature:
- Macro INPUT_TRIM_SYNC_EN.
- When defined: B passes through a 2-flop synchronizer before P/event detection. All press latencies grow by 2 cycles; the synchronizer flops reset to 0.
- When undefined: buttons are sampled directly (1-cycle latency as above).

Test Plan:
- Reset, level=2 (MAX=12); pulse botton_1 for 1 cycle, then botton_2 -> trimmed_inp_1=0, trimmed_inp_2=1, i=2, end_signal=0, error_code=0000.
- botton_3 and botton_4 pressed together -> no slot written, i unchanged, error_code=0001; next valid botton_5 press -> stored 3'd4, error_code=0000.
- botton_6 held 6 cycles -> exactly one slot written (3'd5), i increments by 1 only.
- Twelve valid presses at level=2 -> end_signal rises on the 12th; a further botton_8 press -> no write, i=12, error_code=0010.
- level=3, 16 presses cycling botton_1..8 -> trimmed_inp_1..16 = 0..7,0..7; end_signal=1 after the 16th.
- Assert rst mid-sequence (after 5 presses) asynchronously between edges -> all outputs 0 immediately; after release, the next press lands in trimmed_inp_1.
